// File: rtl/window_max_pkg.sv
// Shared definitions for the peak detector and its sibling minimum selector:
// FSM state encoding and the default sample width of the phase datapath.
package window_max_pkg;

    localparam int DATA_W = 13;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/window_max_if.sv
// Sample-in / result-out bundle of the peak detector. Both sides use plain
// valid/ready: a transfer happens on every rising edge where valid && ready.
interface window_max_if #(
    parameter int DW    = 13,
    parameter int IDX_W = 8
);
    logic             s_valid;
    logic [DW-1:0]    s_data;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_max;
    logic [IDX_W-1:0] m_idx;

    // master: the environment feeding samples and taking results
    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_max, m_idx
    );

    // slave: the peak detector itself
    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_max, m_idx
    );
endinterface

// File: rtl/window_max.sv
// Streaming peak detector: finds the largest sample and its earliest index
// over each window of WIN_LEN accepted samples, then holds it until taken.
module window_max
    import window_max_pkg::*;
#(
    parameter int DW      = DATA_W,
    parameter int WIN_LEN = 256,
    parameter int IDX_W   = $clog2(WIN_LEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         arm,
    input  logic         clr,
    window_max_if.slave  bus,
    output state_e       dbg_state_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(WIN_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    max_q, max_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DW-1:0]    out_max_q, out_max_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;

    logic accept;
    logic last_acc;
    logic take;

    assign accept   = (state_q == ACCUM) && bus.s_valid;
    assign last_acc = accept && (cnt_q == LAST);
    // First sample of a window always loads; later ones only on a strict win.
    assign take     = accept && ((cnt_q == '0) || (bus.s_data > max_q));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (arm) state_d = ACCUM;
            ACCUM:   if (last_acc) state_d = HOLD;
            HOLD:    if (bus.m_ready) state_d = arm ? ACCUM : IDLE;
            default: state_d = IDLE;
        endcase
        if (clr) state_d = IDLE;
    end

    always_comb begin
        bus.s_ready = (state_q == ACCUM);
        bus.m_valid = (state_q == HOLD);
    end

    always_comb begin
        cnt_d     = cnt_q;
        max_d     = max_q;
        idx_d     = idx_q;
        out_max_d = out_max_q;
        out_idx_d = out_idx_q;
        if (accept) cnt_d = last_acc ? '0 : cnt_q + IDX_W'(1);
        if (take) begin
            max_d = bus.s_data;
            idx_d = cnt_q;
        end
        // The result register takes the post-compare value so the last
        // sample is already included in the cycle HOLD is entered.
        if (last_acc) begin
            out_max_d = max_d;
            out_idx_d = idx_d;
        end
        if (clr) begin
            cnt_d     = '0;
            max_d     = '0;
            idx_d     = '0;
            out_max_d = '0;
            out_idx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            max_q     <= '0;
            idx_q     <= '0;
            out_max_q <= '0;
            out_idx_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            max_q     <= max_d;
            idx_q     <= idx_d;
            out_max_q <= out_max_d;
            out_idx_q <= out_idx_d;
        end
    end

    assign bus.m_max   = out_max_q;
    assign bus.m_idx   = out_idx_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/window_max.md
# window_max

Streaming peak detector for the phase-measurement datapath: accepts unsigned 13-bit samples over a valid/ready handshake, tracks the largest value and its position across a fixed window of WIN_LEN samples, then holds the result on a valid/ready output until taken. It complements the combinational minimum selector and feeds fringe-amplitude and normalisation logic that needs the per-window peak.

## Interface
- DW, 13: sample width, unsigned.
- WIN_LEN, 256: samples per window, at least 2.
- IDX_W, $clog2(WIN_LEN): width of the index and counter.

- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- arm  in  1  level enable; starts and continues windows.
- clr  in  1  synchronous abort; discards the partial window and any held result.
- s_valid  in  1  input sample valid.
- s_data  in  DW  input sample.
- s_ready  out  1  block accepts a sample this cycle.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_max  out  DW  maximum sample of the window.
- m_idx  out  IDX_W  position of the maximum within the window, 0-based.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE: s_ready=0, m_valid=0. Goes to ACCUM on the next cycle when arm=1.
- ACCUM: s_ready=1. Each cycle with s_valid&&s_ready is an accepted sample, and cnt increments.
  - Sample at cnt=0 loads max_r and idx_r=0 unconditionally.
  - Later samples load max_r and idx_r=cnt only when s_data > max_r (strict, unsigned). Ties keep the earliest index.
  - When the sample at cnt=WIN_LEN-1 is accepted, the block enters HOLD and cnt resets to 0.
  - Deasserting arm mid-window has no effect; the window completes.
- HOLD: s_ready=0, m_valid=1, with m_max and m_idx stable. On m_valid&&m_ready the block goes to ACCUM if arm=1, otherwise IDLE.
- clr=1 forces IDLE from any state in the next cycle and clears cnt, max_r and idx_r. In HOLD, this drops the result without a handshake. clr has priority over every other input.
- Gaps in s_valid are allowed and do not advance cnt.
- No arithmetic beyond compare and counter. cnt wraps only through the explicit reset at WIN_LEN-1.

## Timing
- Reset values: s_ready=0, m_valid=0, m_max=0, m_idx=0. The state is IDLE and cnt=0.
- Sample k accepted in cycle t is reflected in max_r/idx_r at cycle t+1.
- The last sample of a window is accepted in cycle t. In cycle t+1, m_valid=1 and the outputs include that sample.
- Throughput is one sample per cycle in ACCUM. The gap between windows is at least 1 cycle, the HOLD cycle in which the handshake completes.
- s_ready and m_valid are registered, decoded from state only, and never depend combinationally on s_valid or m_ready.
- m_max and m_idx change only on loading into HOLD, or on clr or reset. Between results they show the last result; they are 0 after clr or reset.
- rst_n low mid-window or in HOLD has the same effect as clr, and reset values apply.
- If clr and the last sample arrive in the same cycle, clr wins and no result is produced.

## Structure
- Shared package window_max_pkg: state enumeration (IDLE, ACCUM, HOLD) and the DW=13 default as the datapath sample-width constant, shared with the minimum selector.
- Single module, no sub-module. The compare, counter and FSM are small enough to stay inline.

## Test plan
Bench uses WIN_LEN=8.
- Basic window: after reset, arm=1, stream 10,300,25,8191,7,0,12,9 back-to-back with m_ready=1. Required: m_valid=1 one cycle after the 8th sample, m_max=8191, m_idx=3. m_valid drops in the next cycle and s_ready reasserts.
- Ties: stream 5,900,900,1,900,2,3,4. Required: m_max=900, m_idx=1.
- Backpressure and gaps: random s_valid gaps, m_ready=0 for 20 cycles after the result. Required: s_ready=0 and m_max/m_idx stable throughout HOLD. No sample is lost or double-counted across the gaps.
- Arm drop: arm=0 after the 3rd sample. Required: the window completes normally, and the block returns to IDLE after the handshake with s_ready=0.
- clr mid-window and clr in HOLD: clr at cnt=5, then a new 8-sample window with all samples 0. Required: m_max=0, m_idx=0, with no carry-over of 8191. clr in HOLD drops m_valid the next cycle.
- Reset mid-operation: rst_n=0 for 1 cycle during ACCUM. Required: all outputs return to their reset values the next cycle and the block is in IDLE.
